// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 message front-end.
package sha256_pkg;

    localparam int       BLK_W          = 512;
    localparam int       LEN_FIELD_W    = 64;
    localparam int       BLK_BYTES      = BLK_W / 8;
    localparam logic [7:0] PAD_MARK     = 8'h80;
    // Highest byte slot that still leaves room for the 64-bit length field.
    localparam int       LAST_DATA_SLOT = 55;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_PAD,
        ST_ISSUE,
        ST_WAIT,
        ST_TAIL
    } pad_state_t;

endpackage

// File: rtl/sha256_pad_mask.sv
// Per-byte keep mask and 0x80 marker placement for a given byte slot.
// Bytes below idx are kept, byte idx receives the marker, the rest clear.
module sha256_pad_mask
    import sha256_pkg::*;
(
    input  logic [5:0]       idx,
    output logic [BLK_W-1:0] keep,
    output logic [BLK_W-1:0] mark
);

    genvar gi;
    generate
        for (gi = 0; gi < BLK_BYTES; gi++) begin : g_byte
            // Byte 0 sits in the most significant lane.
            assign keep[BLK_W-1-8*gi -: 8] = (6'(gi) < idx)  ? 8'hFF    : 8'h00;
            assign mark[BLK_W-1-8*gi -: 8] = (6'(gi) == idx) ? PAD_MARK : 8'h00;
        end
    endgenerate

endmodule

// File: rtl/sha256_padder.sv
// Byte-stream front-end for the SHA-256 core: buffers message bytes,
// appends the 0x80 marker and bit length, and hands out 512-bit blocks
// one at a time, waiting for the core to finish each.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    input  logic [7:0]       IN_BYTE,
    input  logic             IN_LAST,
    output logic             IN_READY,
    output logic             BLK_START,
    output logic [BLK_W-1:0] BLK_DATA,
    output logic             BLK_FIRST,
    input  logic             BLK_DONE,
    output logic             MSG_DONE
);

    pad_state_t             state_reg;
    logic [5:0]             idx_reg;
    logic [LEN_W-1:0]       cnt_reg;
    logic [BLK_W-1:0]       blk_buf_reg;
    logic                   final_blk_reg;
    logic                   mark_pend_reg;
    logic                   closed_reg;     // IN_LAST already accepted
    logic                   first_reg;
    logic                   in_ready_reg;
    logic                   blk_start_reg;
    logic                   blk_first_reg;
    logic                   msg_done_reg;

    logic [BLK_W-1:0]       keep;
    logic [BLK_W-1:0]       mark;
    logic [BLK_W-1:0]       pad_word;
    logic [LEN_FIELD_W-1:0] len_field;

    // Idx is forced to 0 before TAIL, so the same mask serves PAD and TAIL.
    sha256_pad_mask u_mask (
        .idx  (idx_reg),
        .keep (keep),
        .mark (mark)
    );

    assign pad_word  = (blk_buf_reg & keep) | mark;
    assign len_field = LEN_FIELD_W'({cnt_reg, 3'b000});

    assign IN_READY  = in_ready_reg;
    assign BLK_START = blk_start_reg;
    assign BLK_DATA  = blk_buf_reg;
    assign BLK_FIRST = blk_first_reg;
    assign MSG_DONE  = msg_done_reg;

    // Padder FSM with all outputs registered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= ST_FILL;
            idx_reg       <= '0;
            cnt_reg       <= '0;
            blk_buf_reg   <= '0;
            final_blk_reg <= 1'b0;
            mark_pend_reg <= 1'b0;
            closed_reg    <= 1'b0;
            first_reg     <= 1'b1;
            in_ready_reg  <= 1'b1;
            blk_start_reg <= 1'b0;
            blk_first_reg <= 1'b0;
            msg_done_reg  <= 1'b0;
        end else begin
            blk_start_reg <= 1'b0;
            blk_first_reg <= 1'b0;
            msg_done_reg  <= 1'b0;
            case (state_reg)
                ST_FILL: begin
                    if (IN_VALID) begin
                        blk_buf_reg[BLK_W-1-8*int'(idx_reg) -: 8] <= IN_BYTE;
                        cnt_reg <= cnt_reg + LEN_W'(1);
                        idx_reg <= idx_reg + 6'd1;
                        if (IN_LAST)
                            closed_reg <= 1'b1;
                        if (idx_reg == 6'd63) begin
                            // Block is full: ship it now; a last byte here
                            // leaves the marker for a trailing block.
                            state_reg     <= ST_ISSUE;
                            final_blk_reg <= 1'b0;
                            mark_pend_reg <= IN_LAST;
                            in_ready_reg  <= 1'b0;
                            blk_start_reg <= 1'b1;
                            blk_first_reg <= first_reg;
                        end else if (IN_LAST) begin
                            state_reg    <= ST_PAD;
                            in_ready_reg <= 1'b0;
                        end
                    end
                end
                ST_PAD: begin
                    if (idx_reg <= 6'(LAST_DATA_SLOT)) begin
                        blk_buf_reg   <= {pad_word[BLK_W-1:LEN_FIELD_W], len_field};
                        final_blk_reg <= 1'b1;
                    end else begin
                        // No room for the length; it goes in a trailing block.
                        blk_buf_reg   <= pad_word;
                        final_blk_reg <= 1'b0;
                        mark_pend_reg <= 1'b0;
                    end
                    state_reg     <= ST_ISSUE;
                    blk_start_reg <= 1'b1;
                    blk_first_reg <= first_reg;
                end
                ST_ISSUE: begin
                    first_reg <= 1'b0;
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (BLK_DONE) begin
                        idx_reg <= '0;
                        if (final_blk_reg) begin
                            msg_done_reg  <= 1'b1;
                            cnt_reg       <= '0;
                            first_reg     <= 1'b1;
                            closed_reg    <= 1'b0;
                            final_blk_reg <= 1'b0;
                            mark_pend_reg <= 1'b0;
                            state_reg     <= ST_FILL;
                            in_ready_reg  <= 1'b1;
                        end else if (!closed_reg) begin
                            state_reg    <= ST_FILL;
                            in_ready_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_TAIL;
                        end
                    end
                end
                ST_TAIL: begin
                    blk_buf_reg   <= {mark[BLK_W-1:LEN_FIELD_W] & {(BLK_W-LEN_FIELD_W){mark_pend_reg}},
                                      len_field};
                    final_blk_reg <= 1'b1;
                    state_reg     <= ST_ISSUE;
                    blk_start_reg <= 1'b1;
                    blk_first_reg <= first_reg;
                end
                default: begin
                    state_reg    <= ST_FILL;
                    in_ready_reg <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder; the bench plays the role of the core.
module tb_sha256_padder;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         IN_VALID = 1'b0;
    logic [7:0]   IN_BYTE = 8'h00;
    logic         IN_LAST = 1'b0;
    logic         IN_READY;
    logic         BLK_START;
    logic [511:0] BLK_DATA;
    logic         BLK_FIRST;
    logic         BLK_DONE = 1'b0;
    logic         MSG_DONE;

    int n_assert = 0;
    int n_fail   = 0;

    sha256_padder #(.LEN_W(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_BYTE   (IN_BYTE),
        .IN_LAST   (IN_LAST),
        .IN_READY  (IN_READY),
        .BLK_START (BLK_START),
        .BLK_DATA  (BLK_DATA),
        .BLK_FIRST (BLK_FIRST),
        .BLK_DONE  (BLK_DONE),
        .MSG_DONE  (MSG_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One byte offered for one cycle; the padder must be ready.
    task automatic send(input string tag, input logic [7:0] b, input logic last);
        chk({tag, " ready"}, IN_READY, 1'b1);
        IN_VALID = 1'b1;
        IN_BYTE  = b;
        IN_LAST  = last;
        tick();
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
    endtask

    task automatic send_run(input string tag, input logic [7:0] b, input int n, input logic last);
        for (int i = 0; i < n; i++)
            send(tag, b, last && (i == n - 1));
    endtask

    // Core DONE pulse after a few busy cycles.
    task automatic done_pulse();
        repeat (3) tick();
        BLK_DONE = 1'b1;
        tick();
        BLK_DONE = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int k = 0;
        while (BLK_START !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        chk({tag, " start"}, BLK_START, 1'b1);
    endtask

    // Checks following the last byte of a message that fits in one block.
    task automatic single_block(input string tag, input logic [511:0] exp);
        chk({tag, " pad cycle"}, BLK_START, 1'b0);
        tick();
        chk({tag, " start"}, BLK_START, 1'b1);
        chk({tag, " first"}, BLK_FIRST, 1'b1);
        chk({tag, " data"}, BLK_DATA, exp);
        chk({tag, " busy"}, IN_READY, 1'b0);
        tick();
        chk({tag, " start pulse"}, BLK_START, 1'b0);
        chk({tag, " data hold"}, BLK_DATA, exp);
        done_pulse();
        chk({tag, " msg_done"}, MSG_DONE, 1'b1);
        tick();
        chk({tag, " msg_done pulse"}, MSG_DONE, 1'b0);
        chk({tag, " ready again"}, IN_READY, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst in_ready", IN_READY, 1'b1);
        chk("rst start", BLK_START, 1'b0);
        chk("rst data", BLK_DATA, '0);
        chk("rst first", BLK_FIRST, 1'b0);
        chk("rst msg_done", MSG_DONE, 1'b0);
        RST = 1'b0;
        tick();

        // "test"
        send("test", 8'h74, 1'b0);
        send("test", 8'h65, 1'b0);
        send("test", 8'h73, 1'b0);
        send("test", 8'h74, 1'b1);
        single_block("test", {32'h74657374, 8'h80, 408'h0, 64'h20});
        $display("txn test: single block checked");

        // "HDL"
        send("hdl", 8'h48, 1'b0);
        send("hdl", 8'h44, 1'b0);
        send("hdl", 8'h4C, 1'b1);
        single_block("hdl", {24'h48444C, 8'h80, 416'h0, 64'h18});
        $display("txn hdl: single block checked");

        // 56 bytes: marker fits, length spills into a second block
        send_run("a56", 8'h61, 56, 1'b1);
        wait_start("a56 b1");
        chk("a56 b1 data", BLK_DATA, {{56{8'h61}}, 8'h80, 56'h0});
        chk("a56 b1 first", BLK_FIRST, 1'b1);
        done_pulse();
        chk("a56 b1 no msg_done", MSG_DONE, 1'b0);
        chk("a56 tail gap", BLK_START, 1'b0);
        tick();
        chk("a56 b2 start", BLK_START, 1'b1);
        chk("a56 b2 data", BLK_DATA, {448'h0, 64'h1C0});
        chk("a56 b2 first", BLK_FIRST, 1'b0);
        done_pulse();
        chk("a56 msg_done", MSG_DONE, 1'b1);
        tick();
        $display("txn a56: two blocks checked");

        // 64 bytes: block full on last byte, marker and length in tail
        send_run("a64", 8'h61, 64, 1'b1);
        chk("a64 b1 start", BLK_START, 1'b1);
        chk("a64 b1 data", BLK_DATA, {64{8'h61}});
        chk("a64 b1 first", BLK_FIRST, 1'b1);
        done_pulse();
        chk("a64 b1 no msg_done", MSG_DONE, 1'b0);
        tick();
        chk("a64 b2 start", BLK_START, 1'b1);
        chk("a64 b2 data", BLK_DATA, {8'h80, 440'h0, 64'h200});
        chk("a64 b2 first", BLK_FIRST, 1'b0);
        done_pulse();
        chk("a64 msg_done", MSG_DONE, 1'b1);
        tick();
        $display("txn a64: two blocks checked");

        // Backpressure: byte held during WAIT lands in slot 0 of next block
        send_run("bp", 8'h61, 64, 1'b0);
        chk("bp b1 start", BLK_START, 1'b1);
        IN_VALID = 1'b1;
        IN_BYTE  = 8'hFF;
        IN_LAST  = 1'b1;
        repeat (3) tick();
        chk("bp stalled", IN_READY, 1'b0);
        chk("bp no write", BLK_DATA, {64{8'h61}});
        BLK_DONE = 1'b1;
        tick();
        BLK_DONE = 1'b0;
        chk("bp reopen", IN_READY, 1'b1);
        chk("bp no msg_done", MSG_DONE, 1'b0);
        tick();
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
        chk("bp pad cycle", BLK_START, 1'b0);
        tick();
        chk("bp b2 start", BLK_START, 1'b1);
        chk("bp b2 data", BLK_DATA, {8'hFF, 8'h80, 432'h0, 64'h208});
        chk("bp b2 first", BLK_FIRST, 1'b0);
        done_pulse();
        chk("bp msg_done", MSG_DONE, 1'b1);
        tick();
        $display("txn bp: backpressure checked");

        // Reset while waiting on the first block of a two-block message
        send_run("rw", 8'h61, 64, 1'b1);
        chk("rw b1 start", BLK_START, 1'b1);
        tick();
        #1;
        RST = 1'b1;
        #1;
        chk("rw async data", BLK_DATA, '0);
        chk("rw async ready", IN_READY, 1'b1);
        chk("rw async start", BLK_START, 1'b0);
        tick();
        RST = 1'b0;
        BLK_DONE = 1'b1;
        tick();
        BLK_DONE = 1'b0;
        chk("rw no msg_done", MSG_DONE, 1'b0);
        repeat (2) tick();
        chk("rw no start", BLK_START, 1'b0);
        chk("rw still clear", BLK_DATA, '0);
        send("rw test", 8'h74, 1'b0);
        send("rw test", 8'h65, 1'b0);
        send("rw test", 8'h73, 1'b0);
        send("rw test", 8'h74, 1'b1);
        single_block("rw test", {32'h74657374, 8'h80, 408'h0, 64'h20});
        $display("txn rw: reset abort checked");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
